// File: rtl/jk_ff_pkg.sv
// Shared types and the per-bit next-state function for the multi-mode flip-flop bank.
package jk_ff_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // Returns {illegal, q_next}; illegal only flags S=R=1 in SR mode, enable is applied by the caller.
  function automatic logic [1:0] next_state(input mode_e mode, input logic q,
                                            input logic j, input logic k);
    logic illegal;
    logic q_next;
    illegal = 1'b0;
    q_next  = q;
    unique case (mode)
      MODE_JK: begin
        unique case ({j, k})
          2'b00:   q_next = q;
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: q_next = ~q;
        endcase
      end
      MODE_D:  q_next = j;
      MODE_T:  q_next = q ^ j;
      default: begin
        unique case ({j, k})
          2'b00:   q_next = q;
          2'b01:   q_next = 1'b0;
          2'b10:   q_next = 1'b1;
          default: begin
            q_next  = q;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
    return {illegal, q_next};
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: combinational next state plus the bit register.
module ff_cell
  import jk_ff_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  mode_e mode,
  input  logic  j,
  input  logic  k,
  output logic  q,
  output logic  q_next,
  output logic  illegal
);

  logic       q_reg;
  logic [1:0] ns;

  always_comb begin
    ns      = next_state(mode, q_reg, j, k);
    q_next  = en ? ns[0] : q_reg;
    illegal = en & ns[1];
  end

  always_ff @(posedge clk) begin
    if (rst) q_reg <= RESET_BIT;
    else     q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH multi-mode flip-flops with a sticky illegal-SR flag and a saturating change counter.
module jk_ff_bank
  import jk_ff_pkg::*;
#(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  parameter int                 CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sr_err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic             sr_err_reg, sr_err_next;
  logic [CNT_W-1:0] chg_cnt_reg, chg_cnt_next;

  assign mode_sel = mode_e'(mode);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      ff_cell #(
        .RESET_BIT(RESET_VAL[gi])
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode_sel),
        .j      (j[gi]),
        .k      (k[gi]),
        .q      (q[gi]),
        .q_next (q_next[gi]),
        .illegal(illegal[gi])
      );
    end
  endgenerate

  // A new illegal condition beats a same-cycle clear so no event is lost.
  always_comb begin
    sr_err_next = sr_err_reg;
    if (|illegal)    sr_err_next = 1'b1;
    else if (err_clr) sr_err_next = 1'b0;
  end

  always_comb begin
    chg_cnt_next = chg_cnt_reg;
    if (cnt_clr)
      chg_cnt_next = '0;
    else if ((q_next != q) && (chg_cnt_reg != CNT_MAX))
      chg_cnt_next = chg_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_err_reg  <= 1'b0;
      chg_cnt_reg <= '0;
    end else begin
      sr_err_reg  <= sr_err_next;
      chg_cnt_reg <= chg_cnt_next;
    end
  end

  assign qbar    = ~q;
  assign sr_err  = sr_err_reg;
  assign chg_cnt = chg_cnt_reg;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed, scoreboard-driven bench for jk_ff_bank: expectations are queued at drive time and checked after each edge.
module tb_jk_ff_bank;
  import jk_ff_pkg::*;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, err_clr, cnt_clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] q, qbar;
  logic             sr_err;
  logic [CNT_W-1:0] chg_cnt;

  typedef struct {
    string            tag;
    logic [WIDTH-1:0] q;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  logic [WIDTH-1:0] m_q;
  logic             m_err;
  logic [CNT_W-1:0] m_cnt;
  int               n_checks = 0;
  int               n_fail   = 0;

  always #5 clk = ~clk;

  jk_ff_bank #(
    .WIDTH(WIDTH),
    .RESET_VAL(4'b0000),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .err_clr(err_clr), .cnt_clr(cnt_clr),
    .q(q), .qbar(qbar), .sr_err(sr_err), .chg_cnt(chg_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no $finish, required completion");
    $fatal(1, "watchdog");
  end

  // Reference behaviour written from the truth tables, independent of the RTL function.
  task automatic step(input string tag, input logic r, input logic e, input mode_e md,
                      input logic [WIDTH-1:0] jj, input logic [WIDTH-1:0] kk,
                      input logic ec, input logic cc);
    logic [WIDTH-1:0] nq;
    logic             bad;
    exp_t             ex, got;
    rst = r; en = e; mode = md; j = jj; k = kk; err_clr = ec; cnt_clr = cc;
    nq  = m_q;
    bad = 1'b0;
    if (e) begin
      for (int b = 0; b < WIDTH; b++) begin
        case (md)
          MODE_JK: nq[b] = (jj[b] & ~m_q[b]) | (~kk[b] & m_q[b]);
          MODE_D:  nq[b] = jj[b];
          MODE_T:  nq[b] = jj[b] ? ~m_q[b] : m_q[b];
          default: begin
            if (jj[b] && kk[b]) bad = 1'b1;
            else if (jj[b])     nq[b] = 1'b1;
            else if (kk[b])     nq[b] = 1'b0;
          end
        endcase
      end
    end
    if (r) begin
      m_q = '0; m_err = 1'b0; m_cnt = '0;
    end else begin
      if (cc)                          m_cnt = '0;
      else if (nq != m_q && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      if (bad)     m_err = 1'b1;
      else if (ec) m_err = 1'b0;
      m_q = nq;
    end
    ex.tag = tag; ex.q = m_q; ex.err = m_err; ex.cnt = m_cnt;
    exp_q.push_back(ex);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    n_checks++;
    assert (q === got.q) else begin
      n_fail++;
      $error("FAIL %s q: observed %b expected %b", got.tag, q, got.q);
    end
    n_checks++;
    assert (qbar === ~got.q) else begin
      n_fail++;
      $error("FAIL %s qbar: observed %b expected %b", got.tag, qbar, ~got.q);
    end
    n_checks++;
    assert (sr_err === got.err) else begin
      n_fail++;
      $error("FAIL %s sr_err: observed %b expected %b", got.tag, sr_err, got.err);
    end
    n_checks++;
    assert (chg_cnt === got.cnt) else begin
      n_fail++;
      $error("FAIL %s chg_cnt: observed %0d expected %0d", got.tag, chg_cnt, got.cnt);
    end
    $display("%s: q=%b qbar=%b sr_err=%b chg_cnt=%0d", got.tag, q, qbar, sr_err, chg_cnt);
  endtask

  initial begin
    m_q = '0; m_err = 1'b0; m_cnt = '0;
    rst = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0; err_clr = 1'b0; cnt_clr = 1'b0;

    // Reset while the data path would otherwise load 1111
    step("reset", 1, 1, MODE_D, 4'hF, 4'h0, 0, 0);

    // JK truth table and toggling
    step("jk_hold",   0, 1, MODE_JK, 4'h0, 4'h0, 0, 0);
    step("jk_set",    0, 1, MODE_JK, 4'hF, 4'h0, 0, 0);
    step("jk_reset",  0, 1, MODE_JK, 4'h0, 4'hF, 0, 0);
    step("jk_tog1",   0, 1, MODE_JK, 4'hF, 4'hF, 0, 0);
    step("jk_tog2",   0, 1, MODE_JK, 4'hF, 4'hF, 0, 0);
    step("jk_tog3",   0, 1, MODE_JK, 4'hF, 4'hF, 0, 0);
    step("jk_mixed",  0, 1, MODE_JK, 4'b0101, 4'b0011, 0, 0);

    // D, T and clock-enable hold
    step("d_load",    0, 1, MODE_D, 4'hA, 4'h5, 0, 0);
    step("t_tog",     0, 1, MODE_T, 4'h3, 4'hF, 0, 0);
    step("en_hold",   0, 0, MODE_T, 4'hF, 4'hF, 0, 0);
    step("en_hold_d", 0, 0, MODE_D, 4'h0, 4'h0, 0, 0);

    // SR mode, illegal flag, clear and set-wins collision
    step("sr_illegal",  0, 1, MODE_SR, 4'b0011, 4'b0110, 0, 0);
    step("sr_errclr",   0, 1, MODE_SR, 4'h0, 4'h0, 1, 0);
    step("sr_setwins",  0, 1, MODE_SR, 4'b0001, 4'b0001, 1, 0);
    step("sr_sticky",   0, 1, MODE_SR, 4'b1000, 4'b0100, 0, 0);
    step("sr_dis_ill",  0, 0, MODE_SR, 4'hF, 4'hF, 1, 0);

    // Counter saturation and clear priority over a same-cycle change
    for (int i = 0; i < 300; i++) step("t_sat", 0, 1, MODE_T, 4'hF, 4'h0, 0, 0);
    step("cnt_clr_tog", 0, 1, MODE_T, 4'hF, 4'h0, 0, 1);
    step("after_clr",   0, 1, MODE_T, 4'h1, 4'h0, 0, 0);

    // Reset in the middle of toggling with the error flag set
    step("set_err",     0, 1, MODE_SR, 4'h2, 4'h2, 0, 0);
    step("tog_pre_rst", 0, 1, MODE_T, 4'h5, 4'h0, 0, 0);
    step("mid_rst",     1, 1, MODE_T, 4'hF, 4'hF, 1, 1);
    step("resume",      0, 1, MODE_T, 4'hF, 4'h0, 0, 0);
    step("resume2",     0, 1, MODE_JK, 4'h8, 4'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
